// File: rtl/fifo_arb_pkg.sv
// Shared constants, types and the round-robin search helper for fifo_wr_arbiter.
package fifo_arb_pkg;

    localparam int DEF_W   = 8;
    localparam int DEF_D   = 8;
    localparam int DEF_N   = 4;
    localparam int STATS_W = 16;
    localparam int MAX_N   = 32;
    localparam int IDX_W   = 5;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // Scan from last+1 (mod n) for the first asserted valid.
    function automatic rr_pick_t rr_next(
        input logic [MAX_N-1:0] valid,
        input logic [IDX_W-1:0] last,
        input int unsigned      n
    );
        rr_pick_t    r;
        int unsigned j;
        r = '0;
        for (int unsigned k = 1; k <= MAX_N; k++) begin
            j = (32'(last) + k) % n;
            if (k <= n && !r.found && valid[j[IDX_W-1:0]]) begin
                r.found = 1'b1;
                r.idx   = j[IDX_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_arbiter.sv
// Combinational round-robin picker; one-hot grant gated by enable.
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    input  logic                 enable,
    output logic [N-1:0]         gnt
);

    rr_pick_t pick;

    always_comb begin
        pick = rr_next(MAX_N'(req), IDX_W'(last), N);
        gnt  = '0;
        for (int i = 0; i < N; i++) begin
            gnt[i] = enable && pick.found && (pick.idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for sync_fifo with credit-based full protection.
// Optional per-requester accept counters under FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int D = DEF_D,
    parameter int N = DEF_N
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           req_valid,
    input  logic [N*W-1:0]         req_data,
    output logic [N-1:0]           req_ready,
    output logic                   fifo_w_en,
    output logic [W-1:0]           fifo_data_in,
    input  logic                   fifo_full,
    input  logic                   fifo_r_en,
    input  logic                   fifo_empty,
    output logic [$clog2(N)-1:0]   grant_id,
    output logic [$clog2(D+1)-1:0] credits,
    output logic                   err_overflow
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [N*STATS_W-1:0]   grant_cnt
`endif
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(D+1);

    logic [CW-1:0] credits_q, credits_d;
    logic [IW-1:0] last_q, last_d;
    logic [IW-1:0] gid_q, gid_d;
    logic [W-1:0]  data_q, data_d;
    logic          wen_q, wen_d;
    logic          err_q, err_d;
    logic [N-1:0]  gnt;
    logic [IW-1:0] win_idx;
    logic          accept;
    logic          rd_ok;

    // Readiness depends only on valid, last and credits; never on data.
    rr_arbiter #(.N(N)) u_rr (
        .req    (req_valid),
        .last   (last_q),
        .enable ((credits_q != '0) && !rst),
        .gnt    (gnt)
    );

    assign req_ready = gnt;
    assign accept    = |(req_valid & gnt);
    assign rd_ok     = fifo_r_en && !fifo_empty;

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) win_idx = IW'(i);
        end
    end

    always_comb begin
        credits_d = credits_q;
        last_d    = last_q;
        gid_d     = gid_q;
        data_d    = data_q;
        wen_d     = accept;
        err_d     = err_q | (wen_q & fifo_full);
        if (accept && !rd_ok) begin
            credits_d = credits_q - CW'(1);
        end else if (!accept && rd_ok && credits_q != CW'(D)) begin
            credits_d = credits_q + CW'(1);
        end
        if (accept) begin
            last_d = win_idx;
            gid_d  = win_idx;
            data_d = req_data[win_idx*W +: W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credits_q <= CW'(D);
            last_q    <= IW'(N-1);
            gid_q     <= '0;
            data_q    <= '0;
            wen_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            credits_q <= credits_d;
            last_q    <= last_d;
            gid_q     <= gid_d;
            data_q    <= data_d;
            wen_q     <= wen_d;
            err_q     <= err_d;
        end
    end

    assign fifo_w_en    = wen_q;
    assign fifo_data_in = data_q;
    assign grant_id     = gid_q;
    assign credits      = credits_q;
    assign err_overflow = err_q;

`ifdef FIFO_WR_ARB_STATS_EN
    logic [STATS_W-1:0] cnt_q [N];
    logic [STATS_W-1:0] cnt_d [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = cnt_q[i];
            if (req_valid[i] && gnt[i] && cnt_q[i] != '1) begin
                cnt_d[i] = cnt_q[i] + STATS_W'(1);
            end
            grant_cnt[i*STATS_W +: STATS_W] = cnt_q[i];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst) cnt_q[i] <= '0;
            else     cnt_q[i] <= cnt_d[i];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: vector table plus multi-cycle sequences.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_w_en;
    logic [7:0]  fifo_data_in;
    logic        fifo_full;
    logic        fifo_r_en;
    logic        fifo_empty;
    logic [1:0]  grant_id;
    logic [3:0]  credits;
    logic        err_overflow;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [63:0] grant_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int occ;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.W(8), .D(8), .N(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_w_en    (fifo_w_en),
        .fifo_data_in (fifo_data_in),
        .fifo_full    (fifo_full),
        .fifo_r_en    (fifo_r_en),
        .fifo_empty   (fifo_empty),
        .grant_id     (grant_id),
        .credits      (credits),
        .err_overflow (err_overflow)
`ifdef FIFO_WR_ARB_STATS_EN
        ,
        .grant_cnt    (grant_cnt)
`endif
    );

    // Occupancy model of the downstream depth-8 FIFO.
    assign fifo_full  = (occ == 8);
    assign fifo_empty = (occ == 0);

    always @(posedge clk) begin
        if (rst) occ <= 0;
        else occ <= occ + ((fifo_w_en && occ < 8) ? 1 : 0)
                        - ((fifo_r_en && occ > 0) ? 1 : 0);
    end

    typedef struct {
        logic [3:0] valid;
        logic       rd;
        logic [3:0] ready;
        logic       wen;
        logic [1:0] gid;
        logic [7:0] data;
        logic [3:0] cr;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs sampled 3 units later.
    task automatic cyc(input logic [3:0] v, input logic rd, input logic r);
        @(posedge clk);
        #1;
        req_valid = v;
        fifo_r_en = rd;
        rst       = r;
        #3;
    endtask

    initial begin
        logic [3:0] alt [4];
        rst       = 1'b1;
        req_valid = '0;
        fifo_r_en = 1'b0;
        req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

        vecs[0]  = '{4'hF, 0, 4'h1, 0, 2'd0, 8'h00, 4'd8};
        vecs[1]  = '{4'hF, 0, 4'h2, 1, 2'd0, 8'hA0, 4'd7};
        vecs[2]  = '{4'hF, 0, 4'h4, 1, 2'd1, 8'hA1, 4'd6};
        vecs[3]  = '{4'hF, 0, 4'h8, 1, 2'd2, 8'hA2, 4'd5};
        vecs[4]  = '{4'hF, 0, 4'h1, 1, 2'd3, 8'hA3, 4'd4};
        vecs[5]  = '{4'hF, 0, 4'h2, 1, 2'd0, 8'hA0, 4'd3};
        vecs[6]  = '{4'hF, 0, 4'h4, 1, 2'd1, 8'hA1, 4'd2};
        vecs[7]  = '{4'hF, 0, 4'h8, 1, 2'd2, 8'hA2, 4'd1};
        vecs[8]  = '{4'hF, 0, 4'h0, 1, 2'd3, 8'hA3, 4'd0};
        vecs[9]  = '{4'hF, 0, 4'h0, 0, 2'd3, 8'hA3, 4'd0};
        vecs[10] = '{4'h4, 1, 4'h0, 0, 2'd3, 8'hA3, 4'd0};
        vecs[11] = '{4'h4, 0, 4'h4, 0, 2'd3, 8'hA3, 4'd1};
        vecs[12] = '{4'h0, 0, 4'h0, 1, 2'd2, 8'hA2, 4'd0};
        vecs[13] = '{4'h0, 1, 4'h0, 0, 2'd2, 8'hA2, 4'd0};
        vecs[14] = '{4'h0, 1, 4'h0, 0, 2'd2, 8'hA2, 4'd1};
        vecs[15] = '{4'h0, 1, 4'h0, 0, 2'd2, 8'hA2, 4'd2};
        vecs[16] = '{4'h0, 1, 4'h0, 0, 2'd2, 8'hA2, 4'd3};
        vecs[17] = '{4'h1, 1, 4'h1, 0, 2'd2, 8'hA2, 4'd4};
        vecs[18] = '{4'h0, 0, 4'h0, 1, 2'd0, 8'hA0, 4'd4};
        vecs[19] = '{4'h0, 0, 4'h0, 0, 2'd0, 8'hA0, 4'd4};

        cyc(4'h0, 0, 1);
        cyc(4'hF, 0, 1);
        chk("ready_in_rst", 32'(req_ready), 32'h0);

        for (int i = 0; i < 20; i++) begin
            cyc(vecs[i].valid, vecs[i].rd, 1'b0);
            chk($sformatf("v%0d ready", i), 32'(req_ready), 32'(vecs[i].ready));
            chk($sformatf("v%0d w_en", i), 32'(fifo_w_en), 32'(vecs[i].wen));
            chk($sformatf("v%0d gid", i), 32'(grant_id), 32'(vecs[i].gid));
            chk($sformatf("v%0d data", i), 32'(fifo_data_in), 32'(vecs[i].data));
            chk($sformatf("v%0d credits", i), 32'(credits), 32'(vecs[i].cr));
            chk($sformatf("v%0d err", i), 32'(err_overflow), 32'h0);
        end

        // Lone requester 3, then requester 1 joins and they alternate.
        cyc(4'h0, 0, 1);
        cyc(4'h0, 0, 1);
        for (int k = 0; k < 5; k++) begin
            cyc(4'h8, 1, 0);
            chk($sformatf("solo%0d ready", k), 32'(req_ready), 32'h8);
            if (k > 0) begin
                chk($sformatf("solo%0d w_en", k), 32'(fifo_w_en), 32'h1);
                chk($sformatf("solo%0d gid", k), 32'(grant_id), 32'h3);
            end
        end
        alt[0] = 4'h2;
        alt[1] = 4'h8;
        alt[2] = 4'h2;
        alt[3] = 4'h8;
        for (int k = 0; k < 4; k++) begin
            cyc(4'hA, 1, 0);
            chk($sformatf("alt%0d ready", k), 32'(req_ready), 32'(alt[k]));
            chk($sformatf("alt%0d gid", k), 32'(grant_id),
                (k % 2 == 0) ? 32'h3 : 32'h1);
        end
        cyc(4'h0, 0, 0);
        chk("alt_end gid", 32'(grant_id), 32'h3);
        chk("alt_end data", 32'(fifo_data_in), 32'hA3);

        // Reset right after an accept drops the pending write.
        cyc(4'h4, 0, 0);
        chk("pre_rst ready", 32'(req_ready), 32'h4);
        cyc(4'hF, 0, 1);
        chk("mid_rst ready", 32'(req_ready), 32'h0);
        cyc(4'hF, 0, 0);
        chk("post_rst w_en", 32'(fifo_w_en), 32'h0);
        chk("post_rst credits", 32'(credits), 32'd8);
        chk("post_rst ready", 32'(req_ready), 32'h1);
        chk("post_rst gid", 32'(grant_id), 32'h0);
        chk("post_rst data", 32'(fifo_data_in), 32'h0);
        cyc(4'h0, 0, 0);
        chk("post_rst wr w_en", 32'(fifo_w_en), 32'h1);
        chk("post_rst wr gid", 32'(grant_id), 32'h0);
        chk("post_rst wr data", 32'(fifo_data_in), 32'hA0);

`ifdef FIFO_WR_ARB_STATS_EN
        cyc(4'h0, 0, 1);
        cyc(4'h0, 0, 1);
        for (int k = 0; k < 20; k++) cyc(4'h2, 1, 0);
        cyc(4'h0, 1, 0);
        cyc(4'h0, 0, 0);
        chk("cnt0", 32'(grant_cnt[15:0]), 32'd0);
        chk("cnt1", 32'(grant_cnt[31:16]), 32'd20);
        chk("cnt2", 32'(grant_cnt[47:32]), 32'd0);
        chk("cnt3", 32'(grant_cnt[63:48]), 32'd0);
`endif

        chk("final err", 32'(err_overflow), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-side arbiter that shares the single write port of `sync_fifo` among N producers. It accepts per-requester valid/ready transfers, issues registered `w_en`/`data_in` to the FIFO, and keeps a credit counter that mirrors the FIFO's free space, so the FIFO never receives a write while full. It sits between the producer agents and `sync_fifo`; the consumer drives the FIFO read side directly, and the arbiter observes it.

## Interface
- `W`, 8, data width; equals the FIFO `width`
- `D`, 8, FIFO depth; equals the FIFO `depth`; initial credit count
- `N`, 4, number of requesters, ≥2
- `clk`  in  1  single clock for all logic
- `rst`  in  1  synchronous, active-high reset; shared with `sync_fifo`
- `req_valid`  in  N  per-requester write request
- `req_data`  in  N*W  flat; requester i occupies bits [i*W +: W]
- `req_ready`  out  N  combinational; at most one bit set
- `fifo_w_en`  out  1  registered write strobe to the FIFO
- `fifo_data_in`  out  W  registered write data to the FIFO
- `fifo_full`  in  1  FIFO full flag
- `fifo_r_en`  in  1  consumer read strobe, observed only
- `fifo_empty`  in  1  FIFO empty flag
- `grant_id`  out  $clog2(N)  requester index of the current `fifo_w_en`; registered
- `credits`  out  $clog2(D+1)  free-slot count
- `err_overflow`  out  1  sticky; set when `fifo_w_en` and `fifo_full` are both high

## Operation
- Accept: requester i transfers when `req_valid[i] && req_ready[i]`. The requester holds valid and data stable until accepted.
- `req_ready[i]` is high when i is the round-robin winner among the asserted valids **and** `credits > 0`.
  - There is no same-cycle read bypass: with `credits==0`, all readies are 0 even if a read happens in that cycle.
- Round-robin rule: search starts at `last+1` mod N, where `last` is the most recently accepted index. `last` updates only on an accept.
- Credits: `credits_next = credits - accept + rd_ok`, where `rd_ok = fifo_r_en && !fifo_empty`.
  - Simultaneous accept and `rd_ok` leaves credits unchanged.
  - The counter never exceeds D and never underflows.
- Write issue: on an accept, the next cycle has `fifo_w_en=1`, `fifo_data_in=req_data[i]`, `grant_id=i`. Otherwise `fifo_w_en=0`; data and id hold their last values.
- `err_overflow` is set when `fifo_w_en && fifo_full`. It clears only on `rst`. This is a safety check and must never fire in correct use.
- Reset values:
  - `fifo_w_en=0`, `fifo_data_in=0`, `grant_id=0`
  - `credits=D`, `last=N-1` (requester 0 has first priority)
  - `err_overflow=0`, `req_ready=0` during `rst`
- Reset mid-operation drops any registered, not-yet-seen write. Credits return to D, which is consistent because the FIFO is cleared by the same `rst`.

## Timing
- Accept-to-`fifo_w_en` latency: 1 cycle. Throughput: 1 write per cycle while credits > 0.
- Credits decrement in the cycle after an accept. At `credits==1`, one accept is allowed, then ready drops for all requesters.
- `rd_ok` restores a credit in the following cycle, so ready can reassert 1 cycle after the read.
- `req_ready` is a combinational function of `req_valid`, `last` and `credits` only. There is no path from `req_data` to ready.

## Configuration
- `FIFO_WR_ARB_STATS_EN`
  - Defined: adds output `grant_cnt` (N*16, flat). It holds per-requester 16-bit saturating accept counters, reset to 0, and increments on each accept of that requester, saturating at 16'hFFFF.
  - Undefined: the port and the counters are absent; all other behaviour is identical.

## Structure
- Package `fifo_arb_pkg`:
  - default parameter constants (W=8, D=8, N=4)
  - stats counter width (16)
  - function `rr_next(valid, last)` returning the winner index and a found bit
- Sub-module `rr_arbiter`: combinational round-robin picker, parameterised by N. Inputs `req`, `last`, `enable`; one-hot output `gnt`. Instantiated once for the `req_ready` logic.

## Test plan
- Reset, then requesters 0..3 all valid with data 8'hA0..A3 and no reads → accepts in order 0,1,2,3,0,1,2,3. The FIFO receives A0,A1,A2,A3,A0,A1,A2,A3; credits go 8→0 and ready stays 0 afterwards; `fifo_full=1` and `err_overflow=0`.
- FIFO full (credits=0), one read pulse with requester 2 valid → ready[2] rises 1 cycle after the read, a single write is issued, credits return to 0.
- Accept and `rd_ok` in the same cycle at credits=4 → credits remain 4.
- Only requester 3 valid for 5 cycles → 5 consecutive accepts with `grant_id=3`; requester 1 then joins → alternation 1,3,1,3.
- `rst` asserted 1 cycle after an accept → no `fifo_w_en` follows, credits=8, the next grant goes to requester 0.
- With `FIFO_WR_ARB_STATS_EN` defined, 20 accepts by requester 1 → `grant_cnt[1]=20`, others unchanged.
